bitlet_pe_driver: RTL

BITLET_PE_DRIVER -- requirements
Module: bitlet_pe_driver

---
 rtl/bitlet_pe_driver_if.sv | 31 +++
 rtl/bitlet_pe_driver.sv | 112 +++++++++++
 2 files changed

// File: rtl/bitlet_pe_driver_if.sv
// rtl/bitlet_pe_driver_if.sv - job, activation, PE and result handshake bundle for bitlet_pe_driver
interface bitlet_pe_driver_if #(
  parameter int N_input = 16,
  parameter int Wid_bin = 16
);
  logic                       job_vld;
  logic                       job_rdy;
  logic                       in_vld;
  logic                       in_rdy;
  logic [N_input*Wid_bin-1:0] in_data;
  logic                       flush;
  logic                       Abin_vld;
  logic [N_input*Wid_bin-1:0] Abin_vec;
  logic                       res_vld;
  logic [Wid_bin-1:0]         res;
  logic                       out_vld;
  logic                       out_rdy;
  logic [Wid_bin-1:0]         out_data;
  logic                       out_err;
  logic                       stray;

  modport master (
    input  job_vld, in_vld, in_data, res_vld, res, out_rdy,
    output job_rdy, in_rdy, flush, Abin_vld, Abin_vec, out_vld, out_data, out_err, stray
  );

  modport slave (
    output job_vld, in_vld, in_data, res_vld, res, out_rdy,
    input  job_rdy, in_rdy, flush, Abin_vld, Abin_vec, out_vld, out_data, out_err, stray
  );
endinterface

// File: rtl/bitlet_pe_driver.sv
// rtl/bitlet_pe_driver.sv - sequences one job of activation beats into a bitlet PE and returns its result
// Optional watchdog: define BITLET_DRV_TIMEOUT_EN.
module bitlet_pe_driver #(
  parameter int N_total = 64,
  parameter int N_input = 16,
  parameter int Wid_bin = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bitlet_pe_driver_if.master    drv
);
  localparam int BEATS = N_total / N_input;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if ((N_total % N_input) != 0 || BEATS < 1 || TIMEOUT < 2) begin : g_bad_cfg
    $error("bitlet_pe_driver: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, FLUSH, LOAD, WAIT, OUT} state_t;

  state_t                     state, state_nx;
  logic [BW-1:0]              beat_cnt;
  logic                       abin_vld_q;
  logic [N_input*Wid_bin-1:0] abin_vec_q;
  logic [Wid_bin-1:0]         out_data_q;
  logic                       stray_q;
  logic                       in_hs;
  logic                       last_hs;
  logic                       res_hit;
  logic                       timed_out;

  assign in_hs   = (state == LOAD) && drv.in_vld;
  assign last_hs = in_hs && (beat_cnt == LAST_BEAT);
  // The final-beat handshake cycle is still LOAD, so a coincident res_vld falls to stray.
  assign res_hit = (state == WAIT) && drv.res_vld;

`ifdef BITLET_DRV_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT);
  logic [WW-1:0] wdog;
  logic          out_err_q;

  assign timed_out = (state == WAIT) && !drv.res_vld && (wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog      <= '0;
      out_err_q <= 1'b0;
    end else begin
      wdog <= (state == WAIT) ? wdog + WW'(1) : '0;
      if (res_hit)        out_err_q <= 1'b0;
      else if (timed_out) out_err_q <= 1'b1;
    end
  end
  assign drv.out_err = out_err_q;
`else
  assign timed_out   = 1'b0;
  assign drv.out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (drv.job_vld) state_nx = FLUSH;
      FLUSH:   state_nx = LOAD;
      LOAD:    if (last_hs) state_nx = WAIT;
      WAIT:    if (res_hit || timed_out) state_nx = OUT;
      OUT:     if (drv.out_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    drv.job_rdy = (state == IDLE);
    drv.flush   = (state == FLUSH);
    drv.in_rdy  = (state == LOAD);
    drv.out_vld = (state == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      abin_vld_q <= 1'b0;
      abin_vec_q <= '0;
      out_data_q <= '0;
      stray_q    <= 1'b0;
    end else begin
      abin_vld_q <= in_hs;
      if (in_hs) abin_vec_q <= drv.in_data;

      if (state == FLUSH)  beat_cnt <= '0;
      else if (last_hs)    beat_cnt <= '0;
      else if (in_hs)      beat_cnt <= beat_cnt + BW'(1);

      if (res_hit)        out_data_q <= drv.res;
      else if (timed_out) out_data_q <= '0;

      if (drv.res_vld && (state != WAIT)) stray_q <= 1'b1;
    end
  end

  assign drv.Abin_vld = abin_vld_q;
  assign drv.Abin_vec = abin_vec_q;
  assign drv.out_data = out_data_q;
  assign drv.stray    = stray_q;
endmodule
